// File: rtl/fetch_prefetcher.sv
// Instruction-fetch producer: issues word requests, buffers responses in a skid FIFO, pushes to the realign buffer.
// Optional FETCH_PERF_CNT_EN adds saturating grant / dropped-response counters.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module fetch_prefetcher #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_W          = `RISCV_ADDR_WIDTH,
   parameter int DATA_W          = `RISCV_WORD_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en_i,
   input  logic [ADDR_W-1:0] boot_addr_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_gnt_i,
   input  logic              instr_rvalid_i,
   input  logic [DATA_W-1:0] instr_rdata_i,
   output logic              buf_write_en_o,
   output logic [DATA_W-1:0] buf_instr_o,
   output logic [ADDR_W-1:0] buf_addr_o,
   input  logic              buf_full_i,
   output logic              buf_flush_o,
   output logic              buf_skip_half_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       perf_req_cnt_o,
   output logic [31:0]       perf_discard_cnt_o,
`endif
   output logic [1:0]        dbg_state_o
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 2);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_fetch_pc, r_req_addr;
   logic              r_pending, r_stale, r_flush, r_skip_half;
   logic [CNT_W-1:0]  r_outstanding, r_discard, r_skid_cnt;
   logic [ADDR_W-1:0] r_af_addr [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  r_af_wp, r_af_rp;
   logic [DATA_W-1:0] r_skid_data [MAX_OUTSTANDING];
   logic [ADDR_W-1:0] r_skid_addr [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  r_skid_wp, r_skid_rp;

   logic              w_req, w_grant, w_credit, w_redirect, w_drop, w_keep, w_push, w_pend_next;
   logic [CNT_W-1:0]  w_out_next;
   logic              w_unused_bits;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Credits cover both in-flight words and words parked in the skid FIFO.
   assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_skid_cnt}) < CREDITS;

   always_comb begin
      w_state_next = r_state;
      w_req        = r_pending;
      case (r_state)
         ST_IDLE: if (fetch_en_i) w_state_next = ST_RUN;
         ST_RUN: begin
            if (w_credit)    w_req        = 1'b1;
            if (!fetch_en_i) w_state_next = ST_HALT;
         end
         ST_HALT: if (fetch_en_i) w_state_next = ST_RUN;
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_grant     = w_req & instr_gnt_i;
   assign w_pend_next = w_req & ~instr_gnt_i;
   assign w_redirect  = redirect_i & (r_state != ST_IDLE);
   assign w_drop      = instr_rvalid_i & (r_discard != '0);
   assign w_keep      = instr_rvalid_i & (r_discard == '0) & ~w_redirect;
   assign w_push      = (r_skid_cnt != '0) & ~buf_full_i & ~r_flush;
   assign w_out_next  = r_outstanding + CNT_W'(w_grant) - CNT_W'(instr_rvalid_i);

   assign instr_req_o     = w_req;
   assign instr_addr_o    = r_pending ? r_req_addr : r_fetch_pc;
   assign buf_write_en_o  = w_push;
   assign buf_instr_o     = r_skid_data[r_skid_rp];
   assign buf_addr_o      = r_skid_addr[r_skid_rp];
   assign buf_flush_o     = r_flush;
   assign buf_skip_half_o = r_skip_half;
   assign dbg_state_o     = r_state;
   assign w_unused_bits   = ^{boot_addr_i[1:0], redirect_addr_i[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= '0;
         r_req_addr    <= '0;
         r_pending     <= 1'b0;
         r_stale       <= 1'b0;
         r_flush       <= 1'b0;
         r_skip_half   <= 1'b0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_skid_cnt    <= '0;
         r_af_wp       <= '0;
         r_af_rp       <= '0;
         r_skid_wp     <= '0;
         r_skid_rp     <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_af_addr[i]   <= '0;
            r_skid_data[i] <= '0;
            r_skid_addr[i] <= '0;
         end
      end else begin
         r_pending <= w_pend_next;
         if (!r_pending) r_req_addr <= r_fetch_pc;
         // A held request that a redirect overtook must not advance the new target.
         if (w_redirect && w_pend_next) r_stale <= 1'b1;
         else if (w_grant)              r_stale <= 1'b0;

         if (r_state == ST_IDLE) begin
            if (fetch_en_i)      r_fetch_pc <= {boot_addr_i[ADDR_W-1:2], 2'b00};
            else if (redirect_i) r_fetch_pc <= {redirect_addr_i[ADDR_W-1:2], 2'b00};
         end else if (redirect_i) begin
            r_fetch_pc <= {redirect_addr_i[ADDR_W-1:2], 2'b00};
         end else if (w_grant && !r_stale) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
         end

         r_outstanding <= w_out_next;
         if (w_redirect)  r_discard <= w_out_next + CNT_W'(w_pend_next);
         else if (w_drop) r_discard <= r_discard - 1'b1;

         r_flush <= w_redirect;
         if (w_redirect)  r_skip_half <= redirect_addr_i[1];
         else if (w_push) r_skip_half <= 1'b0;

         if (w_grant) begin
            r_af_addr[r_af_wp] <= instr_addr_o;
            r_af_wp            <= ptr_inc(r_af_wp);
         end
         if (instr_rvalid_i) r_af_rp <= ptr_inc(r_af_rp);

         if (w_redirect) begin
            r_skid_wp  <= '0;
            r_skid_rp  <= '0;
            r_skid_cnt <= '0;
         end else begin
            if (w_keep) begin
               r_skid_data[r_skid_wp] <= instr_rdata_i;
               r_skid_addr[r_skid_wp] <= r_af_addr[r_af_rp];
               r_skid_wp              <= ptr_inc(r_skid_wp);
            end
            if (w_push) r_skid_rp <= ptr_inc(r_skid_rp);
            r_skid_cnt <= r_skid_cnt + CNT_W'(w_keep) - CNT_W'(w_push);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_req, r_perf_discard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_req     <= '0;
         r_perf_discard <= '0;
      end else begin
         if (w_grant && (r_perf_req != '1))    r_perf_req     <= r_perf_req + 1'b1;
         if (w_drop && (r_perf_discard != '1)) r_perf_discard <= r_perf_discard + 1'b1;
      end
   end

   assign perf_req_cnt_o     = r_perf_req;
   assign perf_discard_cnt_o = r_perf_discard;
`else
`endif

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Directed bench for fetch_prefetcher: boot, backpressure, redirects, held request, halt, async reset.
module tb_fetch_prefetcher;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en, redirect, gnt, rvalid, buf_full;
   logic [31:0] boot_addr, redirect_addr, rdata;
   logic        req, we, flush, skip;
   logic [31:0] addr, binstr, baddr;
   logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_req, perf_disc;
`endif

   logic [31:0] rsp_q[$];
   logic        rsp_hold;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   fetch_prefetcher dut (
      .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .boot_addr_i(boot_addr),
      .redirect_i(redirect), .redirect_addr_i(redirect_addr),
      .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
      .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
      .buf_write_en_o(we), .buf_instr_o(binstr), .buf_addr_o(baddr),
      .buf_full_i(buf_full), .buf_flush_o(flush), .buf_skip_half_o(skip),
`ifdef FETCH_PERF_CNT_EN
      .perf_req_cnt_o(perf_req), .perf_discard_cnt_o(perf_disc),
`endif
      .dbg_state_o(dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory model: records granted addresses, answers one per cycle unless held.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      hs = req && gnt;
      a  = addr;
      if (hs) rsp_q.push_back(a);
      @(posedge clk);
      #1;
      if (!rsp_hold && rsp_q.size() > 0) begin
         rvalid = 1'b1;
         rdata  = rsp_q.pop_front() ^ KEY;
      end else begin
         rvalid = 1'b0;
         rdata  = '0;
      end
   endtask

   task automatic cyc(input int n, input logic e_req, input logic [31:0] e_addr,
                      input logic e_we, input logic [31:0] e_baddr,
                      input logic e_flush, input logic e_skip);
      #1;
      chk($sformatf("c%0d req", n), 32'(req), 32'(e_req));
      if (e_req) chk($sformatf("c%0d addr", n), addr, e_addr);
      chk($sformatf("c%0d we", n), 32'(we), 32'(e_we));
      if (e_we) begin
         chk($sformatf("c%0d baddr", n), baddr, e_baddr);
         chk($sformatf("c%0d bdata", n), binstr, e_baddr ^ KEY);
      end
      chk($sformatf("c%0d flush", n), 32'(flush), 32'(e_flush));
      chk($sformatf("c%0d skip", n), 32'(skip), 32'(e_skip));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      buf_full = 1'b0; boot_addr = '0; redirect_addr = '0; rdata = '0; rsp_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst req", 32'(req), 32'd0);
      chk("rst addr", addr, 32'd0);
      chk("rst we", 32'(we), 32'd0);
      chk("rst flush", 32'(flush), 32'd0);
      chk("rst skip", 32'(skip), 32'd0);
      chk("rst state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;

      // Boot: low address bits are dropped.
      fetch_en = 1'b1; boot_addr = 32'h101;
      #1;
      chk("c0 idle req", 32'(req), 32'd0);
      chk("c0 state", 32'(dbg_state), 32'd0);
      tick();
      gnt = 1'b1;
      chk("c1 state", 32'(dbg_state), 32'd1);
      cyc(1, 1, 32'h100, 0, 0, 0, 0);        tick();
      cyc(2, 1, 32'h104, 0, 0, 0, 0);        tick();
      cyc(3, 0, 0, 1, 32'h100, 0, 0);        tick();
      cyc(4, 1, 32'h108, 1, 32'h104, 0, 0);  tick();
      cyc(5, 1, 32'h10C, 0, 0, 0, 0);        tick();
      cyc(6, 0, 0, 1, 32'h108, 0, 0);        tick();
      cyc(7, 1, 32'h110, 1, 32'h10C, 0, 0);  tick();

      // Backpressure for 10 cycles.
      buf_full = 1'b1;
      cyc(8, 1, 32'h114, 0, 0, 0, 0);        tick();
      cyc(9, 0, 0, 0, 0, 0, 0);              tick();
      for (int c = 10; c < 18; c++) begin
         cyc(c, 0, 0, 0, 0, 0, 0);           tick();
      end
      buf_full = 1'b0;
      cyc(18, 0, 0, 1, 32'h110, 0, 0);       tick();
      cyc(19, 1, 32'h118, 1, 32'h114, 0, 0); tick();
      cyc(20, 1, 32'h11C, 0, 0, 0, 0);
      rsp_hold = 1'b1;                       tick();
      cyc(21, 0, 0, 1, 32'h118, 0, 0);       tick();
      cyc(22, 1, 32'h120, 0, 0, 0, 0);       tick();

      // Redirect with two outstanding to an upper-halfword target.
      redirect = 1'b1; redirect_addr = 32'h202;
      cyc(23, 0, 0, 0, 0, 0, 0);
      rsp_hold = 1'b0;                       tick();
      redirect = 1'b0;
      cyc(24, 0, 0, 0, 0, 1, 1);             tick();
      cyc(25, 1, 32'h200, 0, 0, 0, 1);       tick();
      cyc(26, 1, 32'h204, 0, 0, 0, 1);       tick();
      cyc(27, 0, 0, 1, 32'h200, 0, 1);       tick();
      cyc(28, 1, 32'h208, 1, 32'h204, 0, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("c28 perf discard", perf_disc, 32'd2);
`endif
      tick();

      // Held request overtaken by a redirect.
      gnt = 1'b0;
      cyc(29, 1, 32'h20C, 0, 0, 0, 0);       tick();
      cyc(30, 1, 32'h20C, 1, 32'h208, 0, 0); tick();
      redirect = 1'b1; redirect_addr = 32'h400;
      cyc(31, 1, 32'h20C, 0, 0, 0, 0);       tick();
      redirect = 1'b0; gnt = 1'b1;
      cyc(32, 1, 32'h20C, 0, 0, 1, 0);       tick();
      cyc(33, 1, 32'h400, 0, 0, 0, 0);       tick();
      cyc(34, 1, 32'h404, 0, 0, 0, 0);       tick();
      cyc(35, 0, 0, 1, 32'h400, 0, 0);       tick();

      // Halt with one outstanding, then resume.
      fetch_en = 1'b0;
      cyc(36, 1, 32'h408, 1, 32'h404, 0, 0); tick();
      chk("c37 state", 32'(dbg_state), 32'd2);
      cyc(37, 0, 0, 0, 0, 0, 0);             tick();
      cyc(38, 0, 0, 1, 32'h408, 0, 0);       tick();
      fetch_en = 1'b1;
      cyc(39, 0, 0, 0, 0, 0, 0);             tick();
      chk("c40 state", 32'(dbg_state), 32'd1);
      cyc(40, 1, 32'h40C, 0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("c40 perf req", perf_req, 32'd16);
      chk("c40 perf discard", perf_disc, 32'd3);
`endif
      tick();

      // Asynchronous reset in the middle of traffic.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst req", 32'(req), 32'd0);
      chk("arst addr", addr, 32'd0);
      chk("arst state", 32'(dbg_state), 32'd0);
      chk("arst skip", 32'(skip), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
